// File: rtl/cam_pixel_capture_pkg.sv
// Shared types and constants for the camera capture front-end.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  localparam int unsigned ERR_LINE_LEN = 0;
  localparam int unsigned ERR_ODD_BYTE = 1;
  localparam int unsigned ERR_LINE_CNT = 2;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic [7:0] data;
  } cam_bus_t;

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, tagged RGB565 pixel stream and frame status out.
interface cam_pixel_capture_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          PCLK;
  logic          CamHsync;
  logic          CamVsync;
  logic [7:0]    CamData;
  logic          PixValid;
  logic [15:0]   PixData;
  logic [XW-1:0] PixX;
  logic [YW-1:0] PixY;
  logic          FrameStart;
  logic          FrameDone;
  logic [2:0]    ErrFlags;

  modport master (
    output PCLK, CamHsync, CamVsync, CamData,
    input  PixValid, PixData, PixX, PixY, FrameStart, FrameDone, ErrFlags
  );

  modport slave (
    input  PCLK, CamHsync, CamVsync, CamData,
    output PixValid, PixData, PixX, PixY, FrameStart, FrameDone, ErrFlags
  );
endinterface

// File: rtl/cam_pixel_capture_input_sampler.sv
// Samples the camera bus into CLK and flags each PCLK rising edge with a one-cycle strobe.
module cam_input_sampler
  import cam_capture_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       pclk,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] data,
  output cam_bus_t   bus,
  output logic       sample
);
  logic     s1_pclk;
  logic     s2_pclk;
  cam_bus_t s1_bus;

  // Bus is re-registered alongside the strobe so the consumer sees the byte captured with PCLK=1.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_pclk <= 1'b0;
      s2_pclk <= 1'b0;
      s1_bus  <= '0;
      sample  <= 1'b0;
      bus     <= '0;
    end else begin
      s1_pclk <= pclk;
      s1_bus  <= '{hsync: hsync, vsync: vsync, data: data};
      s2_pclk <= s1_pclk;
      sample  <= s1_pclk & ~s2_pclk;
      bus     <= s1_bus;
    end
  end
endmodule

// File: rtl/cam_pixel_capture.sv
// Camera front-end: packs byte pairs into RGB565 pixels tagged with X/Y and tracks frame geometry.
module cam_pixel_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter bit          HI_FIRST = 1'b1
) (
  input logic              CLK,
  input logic              RST_N,
  cam_pixel_capture_if.slave cam
);
  // Counters carry one extra bit so they can hold the saturated H_ACTIVE/V_ACTIVE value.
  localparam int unsigned XCW = XW + 1;
  localparam int unsigned YCW = YW + 1;
  localparam logic [XCW-1:0] X_END = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] Y_END = YCW'(V_ACTIVE);

  cam_bus_t        bus;
  logic            sample;
  cap_state_e      state;
  logic [XCW-1:0]  x;
  logic [YCW-1:0]  y;
  logic            phase;
  logic            prev_href;
  logic            frame_bad;
  logic            y_over;
  logic [7:0]      first_byte;
  logic            pix_valid;
  logic [15:0]     pix_data;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  logic            frame_start;
  logic            frame_done;
  logic [2:0]      err;

  cam_input_sampler u_sampler (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .pclk   (cam.PCLK),
    .hsync  (cam.CamHsync),
    .vsync  (cam.CamVsync),
    .data   (cam.CamData),
    .bus    (bus),
    .sample (sample)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      prev_href   <= 1'b0;
      frame_bad   <= 1'b0;
      y_over      <= 1'b0;
      first_byte  <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (sample) begin
        case (state)
          ST_IDLE: if (bus.vsync) state <= ST_VSYNC;
          ST_VSYNC: begin
            if (!bus.vsync) begin
              state       <= ST_ACTIVE;
              frame_start <= 1'b1;
              x           <= '0;
              y           <= '0;
              phase       <= 1'b0;
              prev_href   <= 1'b0;
              frame_bad   <= 1'b0;
              y_over      <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (bus.vsync) begin
              // Vsync has priority over any byte on the same event; an open line is truncated.
              state <= ST_VSYNC;
              if (prev_href) err[ERR_LINE_LEN] <= 1'b1;
              if ((y != Y_END) || y_over) err[ERR_LINE_CNT] <= 1'b1;
              else if (!frame_bad && !prev_href) frame_done <= 1'b1;
            end else if (bus.hsync) begin
              prev_href <= 1'b1;
              if (!phase) begin
                first_byte <= bus.data;
                phase      <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (x != X_END) begin
                  x <= x + 1'b1;
                  if (y != Y_END) begin
                    pix_valid <= 1'b1;
                    pix_data  <= HI_FIRST ? {first_byte, bus.data} : {bus.data, first_byte};
                    pix_x     <= x[XW-1:0];
                    pix_y     <= y[YW-1:0];
                  end
                end else begin
                  err[ERR_LINE_LEN] <= 1'b1;
                  frame_bad         <= 1'b1;
                end
              end
            end else if (prev_href) begin
              prev_href <= 1'b0;
              x         <= '0;
              phase     <= 1'b0;
              if (x != X_END) begin
                err[ERR_LINE_LEN] <= 1'b1;
                frame_bad         <= 1'b1;
              end
              if (phase) begin
                err[ERR_ODD_BYTE] <= 1'b1;
                frame_bad         <= 1'b1;
              end
              if (y != Y_END) y <= y + 1'b1;
              else            y_over <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cam.PixValid   = pix_valid;
  assign cam.PixData    = pix_data;
  assign cam.PixX       = pix_x;
  assign cam.PixY       = pix_y;
  assign cam.FrameStart = frame_start;
  assign cam.FrameDone  = frame_done;
  assign cam.ErrFlags   = err;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture: two instances differing only in byte order.
module tb_cam_pixel_capture;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pclk = 1'b0;
  logic       href = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] data = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fs_cnt   = 0;
  int fd_cnt   = 0;
  int lat_exp  = 0;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    int          cyc;
  } pix_t;
  pix_t q_hi[$];
  pix_t q_lo[$];

  cam_pixel_capture_if #(.XW(XW), .YW(YW)) if_hi ();
  cam_pixel_capture_if #(.XW(XW), .YW(YW)) if_lo ();

  assign if_hi.PCLK = pclk;   assign if_lo.PCLK = pclk;
  assign if_hi.CamHsync = href; assign if_lo.CamHsync = href;
  assign if_hi.CamVsync = vsync; assign if_lo.CamVsync = vsync;
  assign if_hi.CamData = data; assign if_lo.CamData = data;

  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .HI_FIRST(1'b1)) dut_hi (
    .CLK(clk), .RST_N(rst_n), .cam(if_hi.slave));
  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .HI_FIRST(1'b0)) dut_lo (
    .CLK(clk), .RST_N(rst_n), .cam(if_lo.slave));

  always #10ns clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1ns;
    if (if_hi.PixValid === 1'b1)
      q_hi.push_back('{if_hi.PixData, int'(if_hi.PixX), int'(if_hi.PixY), cyc});
    if (if_lo.PixValid === 1'b1)
      q_lo.push_back('{if_lo.PixData, int'(if_lo.PixX), int'(if_lo.PixY), cyc});
    if (if_hi.FrameStart === 1'b1) fs_cnt = fs_cnt + 1;
    if (if_hi.FrameDone === 1'b1) fd_cnt = fd_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input logic vs, input logic hs, input logic [7:0] d);
    @(negedge clk);
    pclk = 1'b0; vsync = vs; href = hs; data = d;
    @(negedge clk);
    pclk = 1'b1;
  endtask

  task automatic vs_phase(input logic vs, input int n);
    for (int i = 0; i < n; i++) drive_byte(vs, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input logic [7:0] b0, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      drive_byte(1'b0, 1'b1, b0 + 8'(i) * step);
      if (i == 1 && lat_exp == 0) lat_exp = cyc + 3;
    end
    vs_phase(1'b0, 2);
  endtask

  task automatic flush();
    repeat (8) @(negedge clk);
  endtask

  task automatic clr();
    q_hi.delete();
    q_lo.delete();
    fs_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b1;
    flush();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(if_hi.PixValid), 32'h0);
    check({tag, "_data"},  32'(if_hi.PixData),  32'h0);
    check({tag, "_x"},     32'(if_hi.PixX),     32'h0);
    check({tag, "_y"},     32'(if_hi.PixY),     32'h0);
    check({tag, "_fs"},    32'(if_hi.FrameStart), 32'h0);
    check({tag, "_fd"},    32'(if_hi.FrameDone),  32'h0);
    check({tag, "_err"},   32'(if_hi.ErrFlags),   32'h0);
  endtask

  initial begin
    // Reset held ~600 ns with bus activity underneath.
    repeat (2) @(negedge clk);
    vs_phase(1'b1, 3);
    vs_phase(1'b0, 3);
    line(6, 8'h11, 8'h01);
    check_idle_outputs("rst");
    check("rst_nopix", 32'(q_hi.size()), 32'd0);
    rst_n = 1'b1;
    flush();

    // Nominal frame
    clr(); lat_exp = 0;
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    line(8, 8'h00, 8'h01); line(8, 8'h00, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("nom_count", 32'(q_hi.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < q_hi.size() && k < q_lo.size()) begin
        logic [7:0] b;
        b = 8'(2 * (k % 4));
        check("nom_data_hi", 32'(q_hi[k].d), 32'({b, b + 8'd1}));
        check("nom_data_lo", 32'(q_lo[k].d), 32'({b + 8'd1, b}));
        check("nom_x", 32'(q_hi[k].x), 32'(k % 4));
        check("nom_y", 32'(q_hi[k].y), 32'(k / 4));
      end
    end
    if (q_hi.size() > 0) check("nom_latency", 32'(q_hi[0].cyc), 32'(lat_exp));
    check("nom_fs", 32'(fs_cnt), 32'd1);
    check("nom_fd", 32'(fd_cnt), 32'd1);
    check("nom_err", 32'(if_hi.ErrFlags), 32'h0);

    // Byte order: constant A5 line then 01,02,...
    clr();
    vs_phase(1'b0, 2);
    line(8, 8'hA5, 8'h00); line(8, 8'h01, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("ord_count", 32'(q_hi.size()), 32'd8);
    if (q_hi.size() == 8 && q_lo.size() == 8) begin
      check("ord_a5_hi", 32'(q_hi[0].d), 32'h0000A5A5);
      check("ord_a5_lo", 32'(q_lo[0].d), 32'h0000A5A5);
      check("ord_0102_hi", 32'(q_hi[4].d), 32'h00000102);
      check("ord_0102_lo", 32'(q_lo[4].d), 32'h00000201);
      check("ord_last_hi", 32'(q_hi[7].d), 32'h00000708);
    end
    check("ord_fd", 32'(fd_cnt), 32'd1);

    // Short line then good line
    clr();
    vs_phase(1'b0, 2);
    line(6, 8'h00, 8'h01); line(8, 8'h20, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("short_count", 32'(q_hi.size()), 32'd7);
    if (q_hi.size() == 7) begin
      check("short_p2_x", 32'(q_hi[2].x), 32'd2);
      check("short_p2_y", 32'(q_hi[2].y), 32'd0);
      check("short_p3_data", 32'(q_hi[3].d), 32'h00002021);
      check("short_p3_y", 32'(q_hi[3].y), 32'd1);
    end
    check("short_err", 32'(if_hi.ErrFlags), 32'h1);
    check("short_fd", 32'(fd_cnt), 32'd0);

    // Next frame still captured, error stays sticky
    clr();
    vs_phase(1'b0, 2);
    line(8, 8'h00, 8'h01); line(8, 8'h00, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("after_count", 32'(q_hi.size()), 32'd8);
    check("after_fd", 32'(fd_cnt), 32'd1);
    check("after_err_sticky", 32'(if_hi.ErrFlags), 32'h1);

    // Odd line (9 bytes)
    do_reset(); clr();
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    line(9, 8'h00, 8'h01); line(8, 8'h10, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("odd_count", 32'(q_hi.size()), 32'd8);
    if (q_hi.size() == 8) begin
      check("odd_p3_data", 32'(q_hi[3].d), 32'h00000607);
      check("odd_p4_data", 32'(q_hi[4].d), 32'h00001011);
      check("odd_p4_x", 32'(q_hi[4].x), 32'd0);
    end
    check("odd_err", 32'(if_hi.ErrFlags), 32'h2);
    check("odd_fd", 32'(fd_cnt), 32'd0);

    // Long line (10 bytes)
    do_reset(); clr();
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    line(10, 8'h00, 8'h01); line(8, 8'h00, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("long_count", 32'(q_hi.size()), 32'd8);
    if (q_hi.size() == 8) begin
      check("long_p4_data", 32'(q_hi[4].d), 32'h00000001);
      check("long_p4_y", 32'(q_hi[4].y), 32'd1);
    end
    check("long_err", 32'(if_hi.ErrFlags), 32'h1);
    check("long_fd", 32'(fd_cnt), 32'd0);

    // Three lines in a two-line frame
    do_reset(); clr();
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    line(8, 8'h00, 8'h01); line(8, 8'h10, 8'h01); line(8, 8'h20, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("tall_count", 32'(q_hi.size()), 32'd8);
    if (q_hi.size() == 8) begin
      check("tall_p7_data", 32'(q_hi[7].d), 32'h00001617);
      check("tall_p7_y", 32'(q_hi[7].y), 32'd1);
    end
    check("tall_err", 32'(if_hi.ErrFlags), 32'h4);
    check("tall_fd", 32'(fd_cnt), 32'd0);

    // Reset asserted mid-line, released mid-line
    do_reset();
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    for (int i = 0; i < 4; i++) drive_byte(1'b0, 1'b1, 8'(i));
    rst_n = 1'b0;
    for (int i = 4; i < 8; i++) drive_byte(1'b0, 1'b1, 8'(i));
    vs_phase(1'b0, 2);
    for (int i = 0; i < 2; i++) drive_byte(1'b0, 1'b1, 8'(i));
    check_idle_outputs("midrst");
    clr();
    rst_n = 1'b1;
    for (int i = 2; i < 8; i++) drive_byte(1'b0, 1'b1, 8'(i));
    vs_phase(1'b0, 2);
    line(8, 8'h00, 8'h01);
    flush();
    check("midrst_nopix", 32'(q_hi.size()), 32'd0);
    check("midrst_nofs", 32'(fs_cnt), 32'd0);
    vs_phase(1'b1, 2); vs_phase(1'b0, 2);
    line(8, 8'h00, 8'h01); line(8, 8'h00, 8'h01);
    vs_phase(1'b1, 2); flush();
    check("midrst_count", 32'(q_hi.size()), 32'd8);
    check("midrst_fs", 32'(fs_cnt), 32'd1);
    check("midrst_fd", 32'(fd_cnt), 32'd1);
    check("midrst_err", 32'(if_hi.ErrFlags), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
